// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - RV64 memory access stage: address check, lane alignment, load extension, writeback beat
module mem_access_stage #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] alu_res,
  input  logic [XLEN-1:0] store_data,
  input  logic [2:0]      funct3,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [4:0]      rd,
  input  logic            reg_write,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  output logic            mem_req_we,
  output logic [XLEN-1:0] mem_req_wdata,
  output logic [7:0]      mem_req_wmask,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic            wb_we,
  output logic [XLEN-1:0] wb_data,
  output logic            exc_valid,
  output logic [XLEN-1:0] exc_addr
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t          state_q;
  logic [2:0]      off_q, f3_q;
  logic [4:0]      rd_q;
  logic            rw_q;
  logic            req_valid_q, req_we_q;
  logic [XLEN-1:0] req_addr_q, req_wdata_q;
  logic [7:0]      req_wmask_q;
  logic            wb_valid_q, wb_we_q, exc_valid_q;
  logic [4:0]      wb_rd_q;
  logic [XLEN-1:0] wb_data_q, exc_addr_q;

  logic            is_mem, illegal, misaligned;
  logic [7:0]      size_mask;
  logic [7:0]      wmask_d;
  logic [XLEN-1:0] wdata_d, field, load_d;

  assign is_mem  = mem_read | mem_write;
  assign illegal = (mem_read & mem_write) | (mem_write & funct3[2]) |
                   (mem_read & (funct3 == 3'b111));

  always_comb begin
    misaligned = 1'b0;
    size_mask  = 8'h01;
    case (funct3[1:0])
      2'b01: begin misaligned = alu_res[0];            size_mask = 8'h03; end
      2'b10: begin misaligned = alu_res[1:0] != 2'b00; size_mask = 8'h0F; end
      2'b11: begin misaligned = alu_res[2:0] != 3'b000; size_mask = 8'hFF; end
      default: ;
    endcase
  end

  assign wdata_d = store_data << {alu_res[2:0], 3'b000};
  assign wmask_d = size_mask << alu_res[2:0];
  assign field   = mem_rdata >> {off_q, 3'b000};

  always_comb begin
    load_d = field;
    case (f3_q)
      3'b000: load_d = {{56{field[7]}},  field[7:0]};
      3'b001: load_d = {{48{field[15]}}, field[15:0]};
      3'b010: load_d = {{32{field[31]}}, field[31:0]};
      3'b100: load_d = {56'd0, field[7:0]};
      3'b101: load_d = {48'd0, field[15:0]};
      3'b110: load_d = {32'd0, field[31:0]};
      default: load_d = field;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      off_q       <= '0;
      f3_q        <= '0;
      rd_q        <= '0;
      rw_q        <= 1'b0;
      req_valid_q <= 1'b0;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_wmask_q <= '0;
      wb_valid_q  <= 1'b0;
      wb_we_q     <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      exc_valid_q <= 1'b0;
      exc_addr_q  <= '0;
    end else begin
      wb_valid_q  <= 1'b0;
      exc_valid_q <= 1'b0;
      case (state_q)
        IDLE: if (in_valid) begin
          if (!is_mem) begin
            wb_valid_q <= 1'b1;
            wb_data_q  <= alu_res;
            wb_rd_q    <= rd;
            wb_we_q    <= reg_write && (rd != 5'd0);
          end else if (illegal || misaligned) begin
            exc_valid_q <= 1'b1;
            exc_addr_q  <= alu_res;
          end else begin
            off_q       <= alu_res[2:0];
            f3_q        <= funct3;
            rd_q        <= rd;
            rw_q        <= reg_write && (rd != 5'd0);
            req_valid_q <= 1'b1;
            req_addr_q  <= {alu_res[XLEN-1:3], 3'b000};
            req_we_q    <= mem_write;
            req_wdata_q <= mem_write ? wdata_d : '0;
            req_wmask_q <= mem_write ? wmask_d : 8'h00;
            state_q     <= REQ;
          end
        end
        REQ: if (mem_req_ready) begin
          req_valid_q <= 1'b0;
          if (req_we_q) begin
            state_q    <= IDLE;
            wb_valid_q <= 1'b1;
            wb_we_q    <= 1'b0;
            wb_rd_q    <= rd_q;
          end else begin
            state_q <= RESP;
          end
        end
        RESP: if (mem_rvalid) begin
          state_q    <= IDLE;
          wb_valid_q <= 1'b1;
          wb_data_q  <= load_d;
          wb_rd_q    <= rd_q;
          wb_we_q    <= rw_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready      = (state_q == IDLE);
  assign mem_req_valid = req_valid_q;
  assign mem_req_addr  = req_addr_q;
  assign mem_req_we    = req_we_q;
  assign mem_req_wdata = req_wdata_q;
  assign mem_req_wmask = req_wmask_q;
  assign wb_valid      = wb_valid_q;
  assign wb_rd         = wb_rd_q;
  assign wb_we         = wb_we_q;
  assign wb_data       = wb_data_q;
  assign exc_valid     = exc_valid_q;
  assign exc_addr      = exc_addr_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed self-checking bench for mem_access_stage
module tb_mem_access_stage;
  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid, in_ready;
  logic [63:0] alu_res, store_data;
  logic [2:0]  funct3;
  logic        mem_read, mem_write, reg_write;
  logic [4:0]  rd;
  logic        mem_req_valid, mem_req_ready, mem_req_we;
  logic [63:0] mem_req_addr, mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic        wb_valid, wb_we, exc_valid;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data, exc_addr;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mem_access_stage dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .alu_res(alu_res), .store_data(store_data), .funct3(funct3),
    .mem_read(mem_read), .mem_write(mem_write), .rd(rd), .reg_write(reg_write),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_we(mem_req_we),
    .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_we(wb_we), .wb_data(wb_data),
    .exc_valid(exc_valid), .exc_addr(exc_addr)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; alu_res = '0; store_data = '0; funct3 = '0;
    mem_read = 0; mem_write = 0; rd = '0; reg_write = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    mem_req_ready = 0; mem_rvalid = 0; mem_rdata = '0;
    rstn = 0;
    step(); step();
    total++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready got %0h exp 1", in_ready); else passed++;
    total++; if (mem_req_valid !== 1'b0) $display("FAIL rst_req_valid got %0h exp 0", mem_req_valid); else passed++;
    total++; if (wb_valid !== 1'b0 || wb_we !== 1'b0 || exc_valid !== 1'b0)
      $display("FAIL rst_pulses got %0h%0h%0h exp 000", wb_valid, wb_we, exc_valid); else passed++;
    total++; if (wb_data !== 64'd0 || wb_rd !== 5'd0 || exc_addr !== 64'd0 || mem_req_addr !== 64'd0)
      $display("FAIL rst_fields got %0h %0h %0h %0h exp 0", wb_data, wb_rd, exc_addr, mem_req_addr); else passed++;
    rstn = 1;
    step();
  endtask

  task automatic test_passthrough();
    in_valid = 1; alu_res = 64'h1234; rd = 5'd5; reg_write = 1;
    for (int i = 0; i < 3; i++) begin
      total++; if (in_ready !== 1'b1) $display("FAIL pt_in_ready[%0d] got %0h exp 1", i, in_ready); else passed++;
      step();
      total++; if (wb_valid !== 1'b1 || wb_we !== 1'b1 || wb_rd !== 5'd5 || wb_data !== 64'h1234)
        $display("FAIL pt_wb[%0d] got v=%0h we=%0h rd=%0d d=%0h exp 1 1 5 1234", i, wb_valid, wb_we, wb_rd, wb_data); else passed++;
    end
    alu_res = 64'hDEAD; rd = 5'd0;
    step();
    total++; if (wb_valid !== 1'b1 || wb_we !== 1'b0 || wb_data !== 64'hDEAD)
      $display("FAIL pt_rd0 got v=%0h we=%0h d=%0h exp 1 0 dead", wb_valid, wb_we, wb_data); else passed++;
    idle_inputs();
    step();
    total++; if (wb_valid !== 1'b0) $display("FAIL pt_pulse_end got %0h exp 0", wb_valid); else passed++;
  endtask

  task automatic test_store(input string nm, input logic [2:0] f3, input logic [63:0] addr,
                            input logic [63:0] sdata, input int stall,
                            input logic [63:0] exp_addr, input logic [63:0] exp_wdata,
                            input logic [7:0] exp_mask);
    mem_req_ready = 0;
    in_valid = 1; mem_write = 1; funct3 = f3; alu_res = addr; store_data = sdata; rd = 5'd7; reg_write = 0;
    step();
    idle_inputs();
    for (int i = 0; i <= stall; i++) begin
      total++; if (mem_req_valid !== 1'b1 || mem_req_we !== 1'b1 || in_ready !== 1'b0)
        $display("FAIL %s_req_ctl[%0d] got v=%0h we=%0h rdy=%0h exp 1 1 0", nm, i, mem_req_valid, mem_req_we, in_ready); else passed++;
      total++; if (mem_req_addr !== exp_addr || mem_req_wdata !== exp_wdata || mem_req_wmask !== exp_mask)
        $display("FAIL %s_req_fields[%0d] got a=%0h d=%0h m=%0h exp %0h %0h %0h", nm, i,
                 mem_req_addr, mem_req_wdata, mem_req_wmask, exp_addr, exp_wdata, exp_mask); else passed++;
      if (i == stall) mem_req_ready = 1;
      step();
    end
    mem_req_ready = 0;
    total++; if (wb_valid !== 1'b1 || wb_we !== 1'b0 || mem_req_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL %s_done got wbv=%0h we=%0h rv=%0h rdy=%0h exp 1 0 0 1", nm, wb_valid, wb_we, mem_req_valid, in_ready); else passed++;
    step();
    total++; if (wb_valid !== 1'b0) $display("FAIL %s_wb_pulse got %0h exp 0", nm, wb_valid); else passed++;
  endtask

  task automatic test_load(input string nm, input logic [2:0] f3, input logic [63:0] addr,
                           input logic [63:0] rdata, input logic [63:0] exp_data);
    mem_req_ready = 1;
    in_valid = 1; mem_read = 1; funct3 = f3; alu_res = addr; rd = 5'd9; reg_write = 1;
    step();
    idle_inputs();
    total++; if (mem_req_valid !== 1'b1 || mem_req_we !== 1'b0 || mem_req_wmask !== 8'h00 ||
                 mem_req_addr !== {addr[63:3], 3'b000})
      $display("FAIL %s_req got v=%0h we=%0h m=%0h a=%0h", nm, mem_req_valid, mem_req_we, mem_req_wmask, mem_req_addr); else passed++;
    step();
    mem_req_ready = 0;
    total++; if (mem_req_valid !== 1'b0 || wb_valid !== 1'b0 || in_ready !== 1'b0)
      $display("FAIL %s_resp_wait got rv=%0h wbv=%0h rdy=%0h exp 0 0 0", nm, mem_req_valid, wb_valid, in_ready); else passed++;
    mem_rvalid = 1; mem_rdata = rdata;
    step();
    mem_rvalid = 0; mem_rdata = '0;
    total++; if (wb_valid !== 1'b1 || wb_we !== 1'b1 || wb_rd !== 5'd9 || wb_data !== exp_data)
      $display("FAIL %s_wb got v=%0h we=%0h rd=%0d d=%0h exp 1 1 9 %0h", nm, wb_valid, wb_we, wb_rd, wb_data, exp_data); else passed++;
    step();
  endtask

  task automatic test_exceptions();
    in_valid = 1; mem_read = 1; funct3 = 3'b010; alu_res = 64'h2002; rd = 5'd3; reg_write = 1;
    step();
    idle_inputs();
    total++; if (exc_valid !== 1'b1 || exc_addr !== 64'h2002)
      $display("FAIL exc_lw got v=%0h a=%0h exp 1 2002", exc_valid, exc_addr); else passed++;
    total++; if (mem_req_valid !== 1'b0 || wb_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL exc_lw_side got rv=%0h wbv=%0h rdy=%0h exp 0 0 1", mem_req_valid, wb_valid, in_ready); else passed++;
    step();
    total++; if (exc_valid !== 1'b0) $display("FAIL exc_pulse got %0h exp 0", exc_valid); else passed++;
    in_valid = 1; mem_write = 1; funct3 = 3'b100; alu_res = 64'h3000;
    step();
    idle_inputs();
    total++; if (exc_valid !== 1'b1 || exc_addr !== 64'h3000 || mem_req_valid !== 1'b0)
      $display("FAIL exc_sw100 got v=%0h a=%0h rv=%0h exp 1 3000 0", exc_valid, exc_addr, mem_req_valid); else passed++;
    step();
  endtask

  task automatic test_reset_mid();
    mem_req_ready = 1;
    in_valid = 1; mem_read = 1; funct3 = 3'b011; alu_res = 64'h2000; rd = 5'd4; reg_write = 1;
    step();
    idle_inputs();
    step();
    mem_req_ready = 0;
    total++; if (in_ready !== 1'b0) $display("FAIL mid_in_resp got %0h exp 0", in_ready); else passed++;
    rstn = 0;
    #1;
    total++; if (in_ready !== 1'b1 || wb_data !== 64'd0)
      $display("FAIL mid_async got rdy=%0h d=%0h exp 1 0", in_ready, wb_data); else passed++;
    step();
    rstn = 1;
    mem_rvalid = 1; mem_rdata = 64'h1111_2222_3333_4444;
    step();
    mem_rvalid = 0;
    total++; if (wb_valid !== 1'b0 || in_ready !== 1'b1 || exc_valid !== 1'b0 || mem_req_valid !== 1'b0)
      $display("FAIL mid_late_rvalid got wbv=%0h rdy=%0h exc=%0h rv=%0h exp 0 1 0 0", wb_valid, in_ready, exc_valid, mem_req_valid); else passed++;
    total++; if (wb_data !== 64'd0 || wb_rd !== 5'd0 || exc_addr !== 64'd0 || mem_req_addr !== 64'd0 || mem_req_wmask !== 8'h00)
      $display("FAIL mid_fields got d=%0h rd=%0d ea=%0h a=%0h m=%0h exp 0", wb_data, wb_rd, exc_addr, mem_req_addr, mem_req_wmask); else passed++;
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_store("sb", 3'b000, 64'h1003, 64'hAB, 3, 64'h1000, 64'hAB00_0000, 8'h08);
    test_store("sh", 3'b001, 64'h1006, 64'hBEEF, 0, 64'h1000, 64'hBEEF_0000_0000_0000, 8'hC0);
    test_load("lb",  3'b000, 64'h2006, 64'h0080_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FF80);
    test_load("lbu", 3'b100, 64'h2006, 64'h0080_0000_0000_0000, 64'h80);
    test_load("lw",  3'b010, 64'h2004, 64'h8000_0001_1234_5678, 64'hFFFF_FFFF_8000_0001);
    test_load("lwu", 3'b110, 64'h2004, 64'h8000_0001_1234_5678, 64'h0000_0000_8000_0001);
    test_load("lh",  3'b001, 64'h2002, 64'h0000_0000_9ABC_0000, 64'hFFFF_FFFF_FFFF_9ABC);
    test_load("ld",  3'b011, 64'h2000, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);
    test_exceptions();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
